uart_rx_fifo: RTL

Byte FIFO directly downstream of the UART receiver. Captures every single-cycle `data_valid`/`data` strobe from the receiver, which cannot be back-pressured, and presents the bytes to the consumer through a first-word-fall-through valid/ready port. Reports fill level and a sticky overflow flag when a received byte is dropped.

---
 rtl/uart_rx_fifo.sv | 74 +++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: non-blocking capture of receiver strobes,
// first-word-fall-through valid/ready output, fill level and sticky overflow flag.
module uart_rx_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A pop in the same cycle frees a slot, so a strobe while full is still accepted.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
